tm1638_frame_ctrl: RTL and testbench

Parametrised successor of the TM1638 segment/LED driver. It latches a full display frame with NUM_GRIDS digits, per-digit LEDs, a brightness level and a display-on flag through a ready/valid handshake. It then emits a sequence of TM1638 command words into the downstream SPI FIFO, using fixed-address mode, and obeys FIFO backpressure. It sits between the application display logic and the SPI word FIFO/serialiser.

---
 rtl/tm1638_frame_ctrl_if.sv | 27 ++
 rtl/tm1638_frame_ctrl.sv | 169 ++++++++++++++++
 tb/tb_tm1638_frame_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tm1638_frame_ctrl_if.sv
// Frame/SPI-word bundle for tm1638_frame_ctrl: frame handshake from the application
// side plus the word/strobe/backpressure link to the SPI word FIFO.
interface tm1638_frame_ctrl_if #(
  parameter int NUM_GRIDS = 8
);
  logic [8*NUM_GRIDS-1:0] segments;
  logic [NUM_GRIDS-1:0]   leds;
  logic [2:0]             brightness;
  logic                   display_on;
  logic                   valid;
  logic                   ready;
  logic                   fifo_full;
  logic [17:0]            data;
  logic                   write;
  logic                   busy;
  logic                   frame_done;

  modport master (
    output segments, leds, brightness, display_on, valid, fifo_full,
    input  ready, data, write, busy, frame_done
  );

  modport slave (
    input  segments, leds, brightness, display_on, valid, fifo_full,
    output ready, data, write, busy, frame_done
  );
endinterface

// File: rtl/tm1638_frame_ctrl.sv
// TM1638 frame controller: latches a display frame and streams fixed-address command
// words into the SPI FIFO. Define TM1638_DIRTY_SKIP_EN to skip words matching the last write.
module tm1638_frame_ctrl #(
  parameter int         NUM_GRIDS = 8,
  parameter logic [7:0] DATA_CMD  = 8'h44,
  parameter int         GRID_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  tm1638_frame_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CTRL = 3'd1,
    DCMD = 3'd2,
    SEG  = 3'd3,
    LED  = 3'd4
  } state_t;

  localparam logic [GRID_W-1:0] LAST_GRID = GRID_W'(NUM_GRIDS - 1);

  state_t                 state_reg, state_next;
  logic [GRID_W-1:0]      grid_reg, grid_next;
  logic [8*NUM_GRIDS-1:0] seg_reg;
  logic [NUM_GRIDS-1:0]   led_reg;
  logic [2:0]             bright_reg;
  logic                   on_reg;
  logic                   done_reg;

  logic        accept;
  logic        emit;
  logic        skip;
  logic        advance;
  logic        write;
  logic        frame_end;
  logic [7:0]  ctrl_byte;
  logic [7:0]  cur_seg;
  logic        cur_led;
  logic [7:0]  seg_addr;
  logic [7:0]  led_addr;
  logic [17:0] word;

  assign accept    = (state_reg == IDLE) && bus.valid;
  assign ctrl_byte = {4'h8, on_reg, bright_reg};
  assign cur_seg   = seg_reg[32'(grid_reg)*8 +: 8];
  assign cur_led   = led_reg[grid_reg];
  assign seg_addr  = 8'hC0 | 8'({grid_reg, 1'b0});
  assign led_addr  = 8'hC0 | 8'({grid_reg, 1'b1});

  assign emit      = (state_reg == CTRL) || (state_reg == DCMD) ||
                     (state_reg == SEG)  || (state_reg == LED);
  // A skipped word always moves on; a real word waits for FIFO space.
  assign advance   = emit && (skip || !bus.fifo_full);
  assign write     = emit && !skip && !bus.fifo_full;
  assign frame_end = (state_reg == LED) && advance && (grid_reg == LAST_GRID);

  always_comb begin
    word = '0;
    case (state_reg)
      CTRL:    word = {2'b01, ctrl_byte, 8'h00};
      DCMD:    word = {2'b01, DATA_CMD, 8'h00};
      SEG:     word = {2'b10, seg_addr, cur_seg};
      LED:     word = {2'b10, led_addr, 7'b0, cur_led};
      default: word = '0;
    endcase
  end

`ifdef TM1638_DIRTY_SKIP_EN
  logic [8*NUM_GRIDS-1:0] seg_shadow_reg;
  logic [NUM_GRIDS-1:0]   led_shadow_reg;
  logic [7:0]             ctrl_shadow_reg;
  logic                   shadow_valid_reg;
  logic                   any_dirty;

  // At DCMD no SEG/LED word has been processed yet, so the whole frame is compared.
  assign any_dirty = (seg_shadow_reg != seg_reg) || (led_shadow_reg != led_reg);

  always_comb begin
    skip = 1'b0;
    if (shadow_valid_reg) begin
      case (state_reg)
        CTRL:    skip = (ctrl_byte == ctrl_shadow_reg);
        DCMD:    skip = !any_dirty;
        SEG:     skip = (cur_seg == seg_shadow_reg[32'(grid_reg)*8 +: 8]);
        LED:     skip = (cur_led == led_shadow_reg[grid_reg]);
        default: skip = 1'b0;
      endcase
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      seg_shadow_reg   <= '0;
      led_shadow_reg   <= '0;
      ctrl_shadow_reg  <= '0;
      shadow_valid_reg <= 1'b0;
    end else begin
      if (write) begin
        case (state_reg)
          CTRL:    ctrl_shadow_reg <= ctrl_byte;
          SEG:     seg_shadow_reg[32'(grid_reg)*8 +: 8] <= cur_seg;
          LED:     led_shadow_reg[grid_reg] <= cur_led;
          default: ;
        endcase
      end
      if (frame_end) shadow_valid_reg <= 1'b1;
    end
  end
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    grid_next  = grid_reg;
    case (state_reg)
      IDLE: if (bus.valid) state_next = CTRL;
      CTRL: if (advance) state_next = DCMD;
      DCMD: if (advance) state_next = SEG;
      SEG:  if (advance) state_next = LED;
      LED: begin
        if (advance) begin
          if (grid_reg == LAST_GRID) begin
            state_next = IDLE;
            grid_next  = '0;
          end else begin
            state_next = SEG;
            grid_next  = grid_reg + GRID_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        grid_next  = '0;
      end
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      grid_reg   <= '0;
      seg_reg    <= '0;
      led_reg    <= '0;
      bright_reg <= '0;
      on_reg     <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      grid_reg  <= grid_next;
      done_reg  <= frame_end;
      if (accept) begin
        seg_reg    <= bus.segments;
        led_reg    <= bus.leds;
        bright_reg <= bus.brightness;
        on_reg     <= bus.display_on;
      end
    end
  end

  // Word and strobe are decoded from state so a held word stays on the bus under backpressure.
  assign bus.data       = word;
  assign bus.write      = write;
  assign bus.ready      = (state_reg == IDLE);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.frame_done = done_reg;

endmodule

// File: tb/tb_tm1638_frame_ctrl.sv
// Directed bench for tm1638_frame_ctrl: table of full frames (with FIFO stalls), then
// mid-frame reset, back-to-back frames, a single-grid instance and the dirty-skip sequence.
module tb_tm1638_frame_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tm1638_frame_ctrl_if #(.NUM_GRIDS(8)) bus8 ();
  tm1638_frame_ctrl_if #(.NUM_GRIDS(1)) bus1 ();

  tm1638_frame_ctrl #(.NUM_GRIDS(8), .DATA_CMD(8'h44), .GRID_W(3)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );
  tm1638_frame_ctrl #(.NUM_GRIDS(1), .DATA_CMD(8'h44), .GRID_W(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  typedef struct packed {
    logic [63:0]         segs;
    logic [7:0]          leds;
    logic [2:0]          bright;
    logic                on;
    int                  stall_at;
    int                  stall_len;
    logic [0:17][17:0]   exp;
  } vec_t;

  vec_t vecs [3];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load8(input logic [63:0] segs, input logic [7:0] leds,
                       input logic [2:0] bright, input logic on);
    bus8.segments   = segs;
    bus8.leds       = leds;
    bus8.brightness = bright;
    bus8.display_on = on;
  endtask

  // One table frame: accept, scramble inputs, apply the stall window, compare every word.
  task automatic run_frame(input int v);
    int widx, stalled, last_wr;
    bit done;
    @(posedge clk);
    load8(vecs[v].segs, vecs[v].leds, vecs[v].bright, vecs[v].on);
    bus8.valid     = 1'b1;
    bus8.fifo_full = 1'b0;
    #1;
    check("idle_ready", bus8.ready, 1);
    check("idle_busy", bus8.busy, 0);
    check("idle_write", bus8.write, 0);
    check("idle_done", bus8.frame_done, 0);
    @(posedge clk);
    bus8.valid = 1'b0;
    load8(~vecs[v].segs, ~vecs[v].leds, ~vecs[v].bright, ~vecs[v].on);
    widx = 0; stalled = 0; last_wr = -10; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (c > 0) @(posedge clk);
      bus8.fifo_full = (widx == vecs[v].stall_at) && (stalled < vecs[v].stall_len);
      #1;
      if (bus8.fifo_full) begin
        check("stall_write", bus8.write, 0);
        check("stall_hold", bus8.data, vecs[v].exp[widx]);
        stalled++;
      end else if (bus8.frame_done) begin
        check("done_count", widx, 18);
        check("done_latency", c - last_wr, 1);
        check("done_write", bus8.write, 0);
        check("done_ready", bus8.ready, 1);
        done = 1'b1;
      end else begin
        check("frame_write", bus8.write, 1);
        check("frame_busy", bus8.busy, 1);
        if (widx < 18) check("frame_word", bus8.data, vecs[v].exp[widx]);
        widx++;
        last_wr = c;
      end
    end
    if (!done) check("frame_timeout", 0, 1);
    bus8.fifo_full = 1'b0;
    $display("frame vec %0d: %0d writes, %0d stall cycles", v, widx, stalled);
  endtask

  // Generic frame on bus8 with fixed LEDs/control; returns the write count and words.
  task automatic collect(input logic [63:0] segs, output int n, output logic [0:17][17:0] w);
    bit done;
    n = 0; w = '0; done = 1'b0;
    @(posedge clk);
    load8(segs, 8'hA5, 3'd7, 1'b1);
    bus8.valid = 1'b1;
    @(posedge clk);
    bus8.valid = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (c > 0) @(posedge clk);
      #1;
      if (bus8.write) begin
        if (n < 18) w[n] = bus8.data;
        n++;
      end
      if (bus8.frame_done) done = 1'b1;
    end
    if (!done) check("collect_timeout", 0, 1);
    $display("collect frame: %0d writes", n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n, widx, last1, first2, done1, last;
    bit done;
    logic [17:0] exp1 [4];
    logic [0:17][17:0] w1, w2, w3;
    logic [63:0] segs_mod;

    vecs[0].segs = 64'h1716151413121110; vecs[0].leds = 8'hA5;
    vecs[0].bright = 3'd7; vecs[0].on = 1'b1;
    vecs[0].stall_at = -1; vecs[0].stall_len = 0;
    vecs[0].exp = {18'h018F00, 18'h014400, 18'h02C010, 18'h02C101, 18'h02C211, 18'h02C300,
                   18'h02C412, 18'h02C501, 18'h02C613, 18'h02C700, 18'h02C814, 18'h02C900,
                   18'h02CA15, 18'h02CB01, 18'h02CC16, 18'h02CD00, 18'h02CE17, 18'h02CF01};
    vecs[1] = vecs[0];
    vecs[1].stall_at = 4; vecs[1].stall_len = 3;
    vecs[2].segs = 64'h8040201008040201; vecs[2].leds = 8'h3C;
    vecs[2].bright = 3'd3; vecs[2].on = 1'b0;
    vecs[2].stall_at = 17; vecs[2].stall_len = 2;
    vecs[2].exp = {18'h018300, 18'h014400, 18'h02C001, 18'h02C100, 18'h02C202, 18'h02C300,
                   18'h02C404, 18'h02C501, 18'h02C608, 18'h02C701, 18'h02C810, 18'h02C901,
                   18'h02CA20, 18'h02CB01, 18'h02CC40, 18'h02CD00, 18'h02CE80, 18'h02CF00};
    exp1 = '{18'h018000, 18'h014400, 18'h02C03F, 18'h02C101};

    rst = 1'b1;
    load8('0, '0, '0, 1'b0);
    bus8.valid = 1'b0; bus8.fifo_full = 1'b0;
    bus1.segments = '0; bus1.leds = '0; bus1.brightness = '0; bus1.display_on = 1'b0;
    bus1.valid = 1'b0; bus1.fifo_full = 1'b0;
    #1;
    check("rst_data", bus8.data, 0);
    check("rst_write", bus8.write, 0);
    check("rst_ready", bus8.ready, 1);
    check("rst_busy", bus8.busy, 0);
    check("rst_done", bus8.frame_done, 0);
    @(posedge clk);
    @(posedge clk);
    rst = 1'b0;

    for (int v = 0; v < 3; v++) run_frame(v);

    // Reset asserted asynchronously after the 5th write of a frame.
    @(posedge clk);
    load8(vecs[0].segs, vecs[0].leds, vecs[0].bright, vecs[0].on);
    bus8.valid = 1'b1;
    @(posedge clk);
    bus8.valid = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 5; c++) begin
      if (c > 0) @(posedge clk);
      #1;
      if (bus8.write) n++;
    end
    check("midrst_pre_writes", n, 5);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_write", bus8.write, 0);
    check("midrst_data", bus8.data, 0);
    check("midrst_ready", bus8.ready, 1);
    check("midrst_busy", bus8.busy, 0);
    @(posedge clk);
    rst = 1'b0;
    $display("mid-frame reset applied after %0d writes", n);
    run_frame(0);

    // Valid held high: back-to-back frames, inputs changed during the first frame.
    @(posedge clk);
    load8(vecs[0].segs, vecs[0].leds, vecs[0].bright, vecs[0].on);
    bus8.valid = 1'b1;
    widx = 0; last1 = -100; first2 = -100; done1 = -100;
    for (int c = 0; c < 100 && widx < 36; c++) begin
      @(posedge clk);
      #1;
      if (bus8.frame_done && done1 < 0) done1 = c;
      if (bus8.write) begin
        if (widx < 18) check("b2b_word1", bus8.data, vecs[0].exp[widx]);
        else           check("b2b_word2", bus8.data, vecs[2].exp[widx-18]);
        if (widx == 0) load8(vecs[2].segs, vecs[2].leds, vecs[2].bright, vecs[2].on);
        if (widx == 17) last1 = c;
        if (widx == 18) first2 = c;
        widx++;
      end
    end
    check("b2b_count", widx, 36);
    check("b2b_done_latency", done1 - last1, 1);
    check("b2b_gap", first2 - last1, 2);
    @(posedge clk);
    bus8.valid = 1'b0;
    #1;
    check("b2b_final_done", bus8.frame_done, 1);
    @(posedge clk);
    #1;
    check("b2b_idle_ready", bus8.ready, 1);
    check("b2b_idle_busy", bus8.busy, 0);
    $display("back-to-back frames: %0d writes, gap %0d", widx, first2 - last1);

    // Single-grid instance.
    @(posedge clk);
    bus1.segments = 8'h3F; bus1.leds = 1'b1; bus1.brightness = 3'd0; bus1.display_on = 1'b0;
    bus1.valid = 1'b1;
    @(posedge clk);
    bus1.valid = 1'b0;
    n = 0; last = -10; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (c > 0) @(posedge clk);
      #1;
      if (bus1.write) begin
        if (n < 4) check("g1_word", bus1.data, exp1[n]);
        n++;
        last = c;
      end
      if (bus1.frame_done) begin
        check("g1_done_latency", c - last, 1);
        done = 1'b1;
      end
    end
    check("g1_count", n, 4);
    if (!done) check("g1_timeout", 0, 1);
    $display("single-grid frame: %0d writes", n);

    // Repeat an identical frame, then change only seg[3].
    @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    segs_mod = vecs[0].segs;
    segs_mod[31:24] = 8'hAA;
    collect(vecs[0].segs, n, w1);
    check("dirty_first_count", n, 18);
    check("dirty_first_ctrl", w1[0], 18'h018F00);
    collect(vecs[0].segs, n, w2);
`ifdef TM1638_DIRTY_SKIP_EN
    check("dirty_same_count", n, 0);
    collect(segs_mod, n, w3);
    check("dirty_change_count", n, 2);
    check("dirty_change_dcmd", w3[0], 18'h014400);
    check("dirty_change_seg3", w3[1], 18'h02C6AA);
`else
    check("repeat_count", n, 18);
    check("repeat_ctrl", w2[0], 18'h018F00);
    collect(segs_mod, n, w3);
    check("change_count", n, 18);
    check("change_seg3", w3[8], 18'h02C6AA);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
